store_buffer: RTL and testbench

Posted-write buffer between the pipelined core's memory stage and data memory. It accepts stores (`MemWrite`, `MemWriteSelect`, `ALUResult`, `WriteData`) into a small FIFO and drains them to memory over a valid/ready write port. Loads are serviced combinationally: data-memory read data is merged with bytes still pending in the buffer, and the result is returned on `ReadData`.

---
 rtl/sb_pkg.sv | 17 +
 rtl/sb_forward.sv | 35 +++
 rtl/store_buffer.sv | 97 +++++++++
 tb/tb_store_buffer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sb_pkg.sv
// Shared types and constants for the store buffer.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package sb_pkg;

  // Entry storage is sized for a 32-bit datapath.
  localparam int SB_XLEN  = 32;
  localparam int SB_DEPTH = 4;

  // One posted store: word address, lane-aligned data and byte strobes.
  typedef struct packed {
    logic [SB_XLEN-3:0] waddr;
    logic [SB_XLEN-1:0] data;
    logic [3:0]         strb;
  } sb_entry_t;

endpackage

// File: rtl/sb_forward.sv
// Per-byte merge of pending store data over memory read data, youngest entry wins.
// Latency: purely combinational, load address to ReadData in the same cycle.
// Backpressure: none; evaluated every cycle regardless of handshakes.
module sb_forward
  import sb_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int PW    = $clog2(DEPTH)
) (
  input  sb_entry_t            entries [DEPTH],
  input  logic [DEPTH-1:0]     valid,
  input  logic [PW-1:0]        head,
  input  logic [SB_XLEN-3:0]   load_waddr,
  input  logic [SB_XLEN-1:0]   mem_rdata,
  output logic [SB_XLEN-1:0]   ReadData
);

  // Walk entries oldest to youngest so a later match overwrites an earlier one per lane.
  always_comb begin
    logic [PW-1:0] idx;
    ReadData = mem_rdata;
    idx      = head;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      if (valid[idx] && (entries[idx].waddr == load_waddr)) begin
        for (int b = 0; b < 4; b++) begin
          if (entries[idx].strb[b]) begin
            ReadData[8*b +: 8] = entries[idx].data[8*b +: 8];
          end
        end
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-write FIFO between the M stage and data memory, with load forwarding.
// Latency: store accepted at edge N is presented on mem_w* in cycle N+1 at the earliest.
// Backpressure: sb_full stalls the core; head holds stable while mem_wready is low.
module store_buffer
  import sb_pkg::*;
#(
  parameter int XLEN  = SB_XLEN,
  parameter int DEPTH = SB_DEPTH
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            MemWrite,
  input  logic [3:0]      MemWriteSelect,
  input  logic [XLEN-1:0] ALUResult,
  input  logic [XLEN-1:0] WriteData,
  output logic [XLEN-1:0] ReadData,
  output logic            sb_full,
  output logic            sb_empty,
  output logic            mem_wvalid,
  input  logic            mem_wready,
  output logic [XLEN-1:0] mem_waddr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_wstrb,
  output logic [XLEN-1:0] mem_raddr,
  input  logic [XLEN-1:0] mem_rdata
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  sb_entry_t        entries [DEPTH];
  logic [DEPTH-1:0] valid;
  logic             enq;
  logic             deq;

  // Byte offset bits only matter to the core's lane alignment; the buffer works on words.
  wire unused_lane_bits = &{1'b0, ALUResult[1:0]};

  assign sb_full    = (count == (PW+1)'(DEPTH));
  assign sb_empty   = (count == '0);
  assign mem_wvalid = !sb_empty;

  // Zero-strobe stores carry nothing and are dropped; full blocks enqueue even on a dequeue cycle.
  assign enq = MemWrite && !sb_full && (MemWriteSelect != 4'b0000);
  assign deq = mem_wvalid && mem_wready;

  assign mem_waddr = {entries[rd_ptr].waddr, 2'b00};
  assign mem_wdata = entries[rd_ptr].data;
  assign mem_wstrb = entries[rd_ptr].strb;
  assign mem_raddr = {ALUResult[XLEN-1:2], 2'b00};

  // Pointer and occupancy bookkeeping; reset discards any pending stores.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage is not reset; only the occupancy decides what is live.
  always_ff @(posedge clk) begin
    if (enq) begin
      entries[wr_ptr] <= '{waddr: ALUResult[XLEN-1:2], data: WriteData, strb: MemWriteSelect};
    end
  end

  // An entry is live when its distance from the head is below the occupancy.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      valid[i] = ({1'b0, PW'(PW'(i) - rd_ptr)} < count);
    end
  end

  sb_forward #(
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_forward (
    .entries    (entries),
    .valid      (valid),
    .head       (rd_ptr),
    .load_waddr (ALUResult[XLEN-1:2]),
    .mem_rdata  (mem_rdata),
    .ReadData   (ReadData)
  );

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with a queue-based reference model.
// Latency: model mirrors edge-by-edge enqueue/dequeue from the rules, not the RTL.
// Backpressure: stalls driven through mem_wready; stores held while sb_full.
module tb_store_buffer;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } st_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        MemWrite = 1'b0;
  logic [3:0]  MemWriteSelect = 4'b0;
  logic [31:0] ALUResult = 32'h0;
  logic [31:0] WriteData = 32'h0;
  logic [31:0] ReadData;
  logic        sb_full;
  logic        sb_empty;
  logic        mem_wvalid;
  logic        mem_wready = 1'b0;
  logic [31:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_raddr;
  logic [31:0] mem_rdata = 32'h0;

  int  n_checks = 0;
  int  n_fail = 0;
  bit  check_en = 1'b0;
  st_t q[$];
  st_t drained[$];
  st_t expected[$];

  always #5 clk = ~clk;

  store_buffer #(.XLEN(32), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .MemWrite       (MemWrite),
    .MemWriteSelect (MemWriteSelect),
    .ALUResult      (ALUResult),
    .WriteData      (WriteData),
    .ReadData       (ReadData),
    .sb_full        (sb_full),
    .sb_empty       (sb_empty),
    .mem_wvalid     (mem_wvalid),
    .mem_wready     (mem_wready),
    .mem_waddr      (mem_waddr),
    .mem_wdata      (mem_wdata),
    .mem_wstrb      (mem_wstrb),
    .mem_raddr      (mem_raddr),
    .mem_rdata      (mem_rdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference load result: memory data overlaid by every pending store, oldest first.
  function automatic logic [31:0] model_read(input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] r;
    r = rd;
    foreach (q[k]) begin
      if (q[k].addr[31:2] == a[31:2]) begin
        for (int b = 0; b < 4; b++) begin
          if (q[k].strb[b]) r[8*b +: 8] = q[k].data[8*b +: 8];
        end
      end
    end
    return r;
  endfunction

  // Model: the pending-store list at each edge, using the pre-edge state for both decisions.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      q.delete();
    end else begin
      bit m_enq;
      bit m_deq;
      m_enq = MemWrite && (q.size() < DEPTH) && (MemWriteSelect != 4'b0);
      m_deq = (q.size() > 0) && mem_wready;
      if (m_deq) begin
        drained.push_back(q[0]);
        void'(q.pop_front());
      end
      if (m_enq) q.push_back('{addr: {ALUResult[31:2], 2'b00}, data: WriteData, strb: MemWriteSelect});
    end
  end

  // Every cycle: flags, head port and forwarded load data against the model.
  always @(negedge clk) begin
    if (check_en && reset) begin
      chk("sb_empty", 32'(sb_empty), 32'(q.size() == 0));
      chk("sb_full", 32'(sb_full), 32'(q.size() == DEPTH));
      chk("mem_wvalid", 32'(mem_wvalid), 32'(q.size() != 0));
      if (q.size() != 0) begin
        chk("mem_waddr", mem_waddr, q[0].addr);
        chk("mem_wdata", mem_wdata, q[0].data);
        chk("mem_wstrb", 32'(mem_wstrb), 32'(q[0].strb));
      end
      chk("mem_raddr", mem_raddr, {ALUResult[31:2], 2'b00});
      chk("ReadData", ReadData, model_read(ALUResult, mem_rdata));
    end
  end

  // Present a store for exactly one edge; caller sits at #1 after an edge.
  task automatic put(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    MemWrite = 1'b1;
    ALUResult = a;
    WriteData = d;
    MemWriteSelect = s;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_empty();
    int t;
    t = 0;
    while (!sb_empty && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("drain_timeout", 32'(sb_empty), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_addr [5];
    bit acc;
    int t;

    // Reset then idle.
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    check_en = 1'b1;
    @(negedge clk);
    chk("rst_empty", 32'(sb_empty), 32'd1);
    chk("rst_full", 32'(sb_full), 32'd0);
    chk("rst_wvalid", 32'(mem_wvalid), 32'd0);
    mem_rdata = 32'hCAFEF00D;
    ALUResult = 32'h0000_0300;
    #1 chk("idle_read", ReadData, 32'hCAFEF00D);
    @(posedge clk); #1;

    // Single store drains straight through.
    mem_wready = 1'b1;
    put(32'h100, 32'hDEADBEEF, 4'b1111);
    MemWrite = 1'b0;
    @(negedge clk);
    chk("single_wvalid", 32'(mem_wvalid), 32'd1);
    chk("single_waddr", mem_waddr, 32'h100);
    chk("single_wdata", mem_wdata, 32'hDEADBEEF);
    @(negedge clk);
    chk("single_empty", 32'(sb_empty), 32'd1);
    @(posedge clk); #1;

    // Fill with memory stalled, hold a fifth store, then drain.
    drained.delete();
    mem_wready = 1'b0;
    for (int i = 0; i < 4; i++) put(32'h400 + 32'(i * 4), 32'h1000 + 32'(i), 4'b1111);
    ALUResult = 32'h500;
    WriteData = 32'h5555_5555;
    MemWriteSelect = 4'b1111;
    @(negedge clk);
    chk("fill_full", 32'(sb_full), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("fill_held_full", 32'(sb_full), 32'd1);
    chk("fill_head", mem_waddr, 32'h400);
    mem_wready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("full_falls", 32'(sb_full), 32'd0);
    @(posedge clk); #1;
    MemWrite = 1'b0;
    wait_empty();
    exp_addr = '{32'h400, 32'h404, 32'h408, 32'h40C, 32'h500};
    chk("fill_drain_cnt", 32'(drained.size()), 32'd5);
    for (int i = 0; i < 5 && i < drained.size(); i++) chk("fill_order", drained[i].addr, exp_addr[i]);
    @(posedge clk); #1;

    // Forwarding: youngest entry wins per lane.
    mem_wready = 1'b0;
    mem_rdata = 32'h11223344;
    put(32'h200, 32'h0000_00AA, 4'b0001);
    put(32'h200, 32'h0000_BBCC, 4'b0011);
    MemWrite = 1'b0;
    ALUResult = 32'h202;
    #1 chk("fwd_202", ReadData, 32'h1122BBCC);
    ALUResult = 32'h204;
    #1 chk("fwd_204", ReadData, 32'h11223344);
    ALUResult = 32'h200;
    #1 chk("fwd_200", ReadData, 32'h1122BBCC);
    mem_wready = 1'b1;
    wait_empty();
    @(posedge clk); #1;

    // Zero-strobe store is dropped.
    mem_wready = 1'b0;
    put(32'h300, 32'h55, 4'b0000);
    MemWrite = 1'b0;
    @(negedge clk);
    chk("zero_strb_empty", 32'(sb_empty), 32'd1);
    @(posedge clk); #1;

    // Asynchronous reset in the middle of a drain.
    for (int i = 0; i < 3; i++) put(32'h600 + 32'(i * 4), 32'(i), 4'b1111);
    MemWrite = 1'b0;
    mem_wready = 1'b1;
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("midrst_empty", 32'(sb_empty), 32'd1);
    chk("midrst_full", 32'(sb_full), 32'd0);
    chk("midrst_wvalid", 32'(mem_wvalid), 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;

    // Wrap-around with random memory stalls.
    drained.delete();
    expected.delete();
    for (int i = 0; i < 10; i++) begin
      MemWrite = 1'b1;
      ALUResult = 32'h1000 + 32'((i % 3) * 4);
      WriteData = 32'hA000_0000 + 32'(i * 17);
      MemWriteSelect = 4'((i % 15) + 1);
      mem_rdata = 32'h0F0F_0000 + 32'(i);
      expected.push_back('{addr: ALUResult, data: WriteData, strb: MemWriteSelect});
      t = 0;
      acc = 1'b0;
      while (!acc && t < 100) begin
        mem_wready = 1'($urandom_range(0, 1));
        @(negedge clk);
        acc = !sb_full;
        @(posedge clk);
        #1;
        t++;
      end
    end
    MemWrite = 1'b0;
    mem_wready = 1'b1;
    wait_empty();
    chk("wrap_cnt", 32'(drained.size()), 32'd10);
    for (int i = 0; i < 10 && i < drained.size(); i++) begin
      chk("wrap_addr", drained[i].addr, expected[i].addr);
      chk("wrap_data", drained[i].data, expected[i].data);
      chk("wrap_strb", 32'(drained[i].strb), 32'(expected[i].strb));
    end

    check_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
